// File: rtl/ifid_stage.sv
// IF/ID pipeline register with load-use / jump-register stall control and a saturating stall counter.
// Define IFID_DELAY_SLOT_EN to treat the IF instruction as a delay slot instead of flushing on redirect.
module ifid_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instruction_if,
    input  logic [31:0]      NextPC_if,
    input  logic             Z,
    input  logic             J,
    input  logic             JR,
    input  logic             MemRead_ex,
    input  logic             RegWrite_ex,
    input  logic [4:0]       WriteReg_ex,
    output logic [31:0]      Instruction_id,
    output logic [31:0]      NextPC_id,
    output logic             valid_id,
    output logic             PC_IFWrite,
    output logic             Stall_id,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      npc_q, npc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0] op, funct;
    logic [4:0] rs, rt;
    logic       uses_rt, is_jr, load_use, jr_use, hazard, redirect;

    assign op    = instr_q[31:26];
    assign rs    = instr_q[25:21];
    assign rt    = instr_q[20:16];
    assign funct = instr_q[5:0];

    assign uses_rt  = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    assign is_jr    = (op == 6'h00) && (funct == 6'h08);
    assign load_use = valid_q && MemRead_ex && (WriteReg_ex != 5'd0) &&
                      ((WriteReg_ex == rs) || (uses_rt && (WriteReg_ex == rt)));
    assign jr_use   = valid_q && is_jr && RegWrite_ex && (WriteReg_ex != 5'd0) &&
                      (WriteReg_ex == rs);
    assign hazard   = load_use || jr_use;
    assign redirect = Z || J || JR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = RUN;
        if (!redirect && (state_q == RUN) && is_jr && load_use) state_d = HOLD;
    end

    always_comb begin
        PC_IFWrite = 1'b1;
        Stall_id   = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard) begin
                    PC_IFWrite = 1'b0;
                    Stall_id   = 1'b1;
                end
            end
            HOLD: begin
                PC_IFWrite = 1'b0;
                Stall_id   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
`ifdef IFID_DELAY_SLOT_EN
        if (PC_IFWrite) begin
            instr_d = Instruction_if;
            npc_d   = NextPC_if;
            valid_d = 1'b1;
        end
`else
        if (redirect) begin
            instr_d = '0;
            npc_d   = NextPC_if;
            valid_d = 1'b0;
        end else if (PC_IFWrite) begin
            instr_d = Instruction_if;
            npc_d   = NextPC_if;
            valid_d = 1'b1;
        end
`endif
        cnt_d = cnt_q;
        // Counter sticks at all-ones rather than wrapping.
        if (!PC_IFWrite && !redirect && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Instruction_id = instr_q;
    assign NextPC_id      = npc_q;
    assign valid_id       = valid_q;
    assign stall_count    = cnt_q;

endmodule

// File: tb/tb_ifid_stage.sv
// Scoreboard bench for ifid_stage: a driver queues expected outputs, a negedge monitor compares them.
`timescale 1ns/1ps
module tb_ifid_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction_if, NextPC_if;
    logic        Z, J, JR, MemRead_ex, RegWrite_ex;
    logic [4:0]  WriteReg_ex;
    logic [31:0] Instruction_id, NextPC_id, Instruction_id4, NextPC_id4;
    logic        valid_id, PC_IFWrite, Stall_id, valid_id4, PC_IFWrite4, Stall_id4;
    logic [15:0] stall_count;
    logic [3:0]  stall_count4;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
        logic        v;
        logic        pcw;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ifid_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .NextPC_if(NextPC_if),
        .Z(Z), .J(J), .JR(JR), .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex),
        .WriteReg_ex(WriteReg_ex), .Instruction_id(Instruction_id), .NextPC_id(NextPC_id),
        .valid_id(valid_id), .PC_IFWrite(PC_IFWrite), .Stall_id(Stall_id),
        .stall_count(stall_count)
    );

    ifid_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .NextPC_if(NextPC_if),
        .Z(Z), .J(J), .JR(JR), .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex),
        .WriteReg_ex(WriteReg_ex), .Instruction_id(Instruction_id4), .NextPC_id(NextPC_id4),
        .valid_id(valid_id4), .PC_IFWrite(PC_IFWrite4), .Stall_id(Stall_id4),
        .stall_count(stall_count4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [3:0] c4;
            e  = sb.pop_front();
            c4 = (e.cnt > 16'd15) ? 4'hF : e.cnt[3:0];
            chk("instr_id",    Instruction_id,      e.instr);
            chk("nextpc_id",   NextPC_id,           e.npc);
            chk("valid_id",    {31'd0, valid_id},   {31'd0, e.v});
            chk("pc_ifwrite",  {31'd0, PC_IFWrite}, {31'd0, e.pcw});
            chk("stall_id",    {31'd0, Stall_id},   {31'd0, e.st});
            chk("stall_count", {16'd0, stall_count}, {16'd0, e.cnt});
            chk("stall_count4", {28'd0, stall_count4}, {28'd0, c4});
        end
    end

    task automatic push(input logic [31:0] ei, input logic [31:0] en, input logic ev,
                        input logic ep, input logic es, input logic [15:0] ec);
        exp_t e;
        e.instr = ei; e.npc = en; e.v = ev; e.pcw = ep; e.st = es; e.cnt = ec;
        sb.push_back(e);
    endtask

    task automatic step(input logic [31:0] ifi, input logic [31:0] npci,
                        input logic z, input logic j, input logic jr,
                        input logic mr, input logic rw, input logic [4:0] wr,
                        input logic [31:0] ei, input logic [31:0] en, input logic ev,
                        input logic ep, input logic es, input logic [15:0] ec);
        Instruction_if = ifi; NextPC_if = npci;
        Z = z; J = j; JR = jr;
        MemRead_ex = mr; RegWrite_ex = rw; WriteReg_ex = wr;
        push(ei, en, ev, ep, es, ec);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        Instruction_if = '0; NextPC_if = '0;
        Z = 1'b0; J = 1'b0; JR = 1'b0;
        MemRead_ex = 1'b0; RegWrite_ex = 1'b0; WriteReg_ex = '0;
        @(posedge clk); #1;
        push(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // hazard-free stream
        step(32'h20080005, 32'd4,  0,0,0, 0,0,5'd0, 32'h00000000, 32'd0,  0,1,0, 16'd0);
        step(32'h20090007, 32'd8,  0,0,0, 0,0,5'd0, 32'h20080005, 32'd4,  1,1,0, 16'd0);
        step(32'h01095020, 32'd12, 0,0,0, 0,0,5'd0, 32'h20090007, 32'd8,  1,1,0, 16'd0);
        // load-use on rt: one stall
        step(32'h01000008, 32'd16, 0,0,0, 1,1,5'd9, 32'h01095020, 32'd12, 1,0,1, 16'd0);
        step(32'h01000008, 32'd16, 0,0,0, 0,0,5'd0, 32'h01095020, 32'd12, 1,1,0, 16'd1);
        // jr after load: RUN stall then HOLD stall
        step(32'h20080005, 32'd20, 0,0,0, 1,1,5'd8, 32'h01000008, 32'd16, 1,0,1, 16'd1);
        step(32'h20080005, 32'd20, 0,0,0, 0,0,5'd0, 32'h01000008, 32'd16, 1,0,1, 16'd2);
        step(32'h20080005, 32'd20, 0,0,0, 0,0,5'd0, 32'h01000008, 32'd16, 1,1,0, 16'd3);
        // load writing $0 with rs=0: no stall
        step(32'h01095020, 32'd24, 0,0,0, 1,1,5'd0, 32'h20080005, 32'd20, 1,1,0, 16'd3);
        // branch taken while load-use active
        step(32'h8C0B0000, 32'd28, 1,0,0, 1,1,5'd8, 32'h01095020, 32'd24, 1,0,1, 16'd3);
`ifdef IFID_DELAY_SLOT_EN
        step(32'h01095020, 32'd32, 0,0,0, 0,0,5'd0, 32'h01095020, 32'd24, 1,1,0, 16'd3);
`else
        step(32'h01095020, 32'd32, 0,0,0, 0,0,5'd0, 32'h00000000, 32'd28, 0,1,0, 16'd3);
`endif
        // 20 consecutive stalls: 16-bit counter reaches 23, 4-bit one sticks at 15
        for (int k = 0; k < 20; k++)
            step(32'h01095020, 32'd32, 0,0,0, 1,1,5'd9, 32'h01095020, 32'd32, 1,0,1, 16'(3 + k));
        step(32'h01000008, 32'd36, 0,0,0, 0,0,5'd0, 32'h01095020, 32'd32, 1,1,0, 16'd23);
        step(32'h01000008, 32'd36, 0,0,0, 1,1,5'd8, 32'h01000008, 32'd36, 1,0,1, 16'd23);

        // now in HOLD: async reset must clear everything before the next edge
        MemRead_ex = 1'b0; RegWrite_ex = 1'b0; WriteReg_ex = '0;
        reset = 1'b1;
        push(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // jr after ALU producer: single stall, no HOLD
        step(32'h01000008, 32'd4, 0,0,0, 0,0,5'd0, 32'h00000000, 32'd0, 0,1,0, 16'd0);
        step(32'h20080005, 32'd8, 0,0,0, 0,1,5'd8, 32'h01000008, 32'd4, 1,0,1, 16'd0);
        step(32'h20080005, 32'd8, 0,0,0, 0,0,5'd0, 32'h01000008, 32'd4, 1,1,0, 16'd1);

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifid_stage.md
# ifid_stage

IF/ID pipeline register with load-use and jump-register hazard control for the 5-stage pipeline CPU. It sits directly downstream of the fetch stage. It captures the fetched instruction and its PC+4, holds them during stalls, and flushes them on control-flow redirects. It drives the fetch stage's PC/IF write enable and the bubble request into ID/EX, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- CNT_W, 16, width of the stall-cycle counter
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- Instruction_if  input  32  instruction word from the fetch stage
- NextPC_if  input  32  PC+4 from the fetch stage
- Z  input  1  branch taken (redirect to branch target)
- J  input  1  jump (redirect to jump target)
- JR  input  1  jump register (redirect to register target)
- MemRead_ex  input  1  instruction in EX is a load
- RegWrite_ex  input  1  instruction in EX writes the register file
- WriteReg_ex  input  5  destination register of the instruction in EX
- Instruction_id  output  32  registered instruction for decode
- NextPC_id  output  32  registered PC+4 for decode
- valid_id  output  1  Instruction_id is a real instruction and not a bubble
- PC_IFWrite  output  1  PC and IF/ID write enable; 0 means stall
- Stall_id  output  1  zero ID control signals into ID/EX this cycle
- stall_count  output  CNT_W  saturating count of stall cycles

## Operation
- Fields:
  - rs = Instruction_id[25:21]
  - rt = Instruction_id[20:16]
  - op = Instruction_id[31:26]
  - funct = Instruction_id[5:0]
- uses_rt is true when op is 0x00, 0x04 (beq), 0x05 (bne) or 0x2B (sw).
- is_jr is true when op is 0x00 and funct is 0x08.
- load_use is true when all of the following hold:
  - valid_id & MemRead_ex
  - WriteReg_ex != 0
  - WriteReg_ex == rs, or (uses_rt and WriteReg_ex == rt)
- jr_use is true when valid_id & is_jr & RegWrite_ex & WriteReg_ex != 0 & WriteReg_ex == rs.
- redirect = Z | J | JR.
- The FSM has two states, RUN and HOLD:
  - In RUN, hazard = load_use | jr_use.
    - If hazard is true: PC_IFWrite = 0 and Stall_id = 1.
    - Next state is HOLD when is_jr & load_use (the load result is needed in ID, so 2 stalls are required). Otherwise next state is RUN.
  - In HOLD, the block forces PC_IFWrite = 0 and Stall_id = 1 unconditionally, then returns to RUN.
- Register update on each clock edge, in priority order:
  - When redirect is true (flush; see Configuration):
    - Instruction_id <= 0 (NOP), valid_id <= 0, NextPC_id <= NextPC_if.
    - State <= RUN.
  - Else when PC_IFWrite = 0: hold all registers.
  - Else capture: Instruction_id <= Instruction_if, NextPC_id <= NextPC_if, valid_id <= 1.
- A redirect and a stall in the same cycle: the flush wins, because the redirecting instruction is older. PC_IFWrite is still driven from hazard logic; the fetch stage only ignores it when the redirect is taken.
- stall_count increments by 1 on every edge where PC_IFWrite = 0 and no redirect occurs. It saturates at all-ones and never wraps.

## Timing
- Values on reset:
  - Instruction_id = 0, NextPC_id = 0, valid_id = 0, stall_count = 0, state = RUN.
  - PC_IFWrite = 1 and Stall_id = 0.
- Reset mid-stall returns to RUN immediately, asynchronously.
- Latency Instruction_if -> Instruction_id is 1 cycle.
- PC_IFWrite and Stall_id are combinational from the state, the IF/ID registers and the EX inputs, with no input-to-input loop.
- Load-use costs 1 stall cycle.
- jr_use caused by an ALU producer costs 1 stall cycle.
- jr_use caused by a load producer costs 2 stall cycles: the RUN cycle with the hazard, then HOLD.
- A bubble (valid_id = 0) never raises a hazard.
- Register 0 never raises a hazard.

## Configuration
- Macro IFID_DELAY_SLOT_EN.
- When defined:
  - redirect does not flush. The instruction in IF is captured normally as the delay slot, subject to stall hold.
  - HOLD is still cleared to RUN on redirect.
- When undefined: redirect flushes IF/ID as described in Operation.

## Test plan
- Reset asserted mid-HOLD -> state RUN, all outputs at their reset values, and PC_IFWrite = 1 before the next edge.
- Stream 0x20080005, 0x20090007 with no hazards -> Instruction_id follows 1 cycle later, valid_id = 1, stall_count stays 0.
- Load-use: Instruction_id = 0x01095020 (add $10,$8,$9), MemRead_ex = 1, WriteReg_ex = 9 -> exactly 1 cycle with PC_IFWrite = 0 and Stall_id = 1, Instruction_id held, stall_count = 1.
- JR after load: Instruction_id = 0x01000008 (jr $8), MemRead_ex = RegWrite_ex = 1, WriteReg_ex = 8 -> 2 stall cycles (RUN then HOLD), stall_count = 2.
- WriteReg_ex = 0 with MemRead_ex = 1 and rs = 0 -> no stall.
- Flush and saturation:
  - Without the macro: Z = 1 while load_use is active -> next cycle Instruction_id = 0, valid_id = 0, state RUN.
  - With IFID_DELAY_SLOT_EN: Instruction_if is captured instead.
  - Separately, with CNT_W = 4 and 20 consecutive stalls -> stall_count = 15.
